// File: rtl/boot_image_writer_if.sv
// Memory write port of the boot image writer.
// The writer (master) drives one 128-bit line request at a time and the
// memory controller (slave) completes it with a one-cycle mem_ack pulse.
interface boot_image_writer_if;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [15:0]  mem_mask;
    logic         mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wdata,
        output mem_mask,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        input  mem_mask,
        output mem_ack
    );
endinterface

// File: rtl/boot_image_writer.sv
// boot_image_writer
// Takes the 32-bit words produced by the SD-card boot loader, acknowledges
// each through the 8-bit controller-state handshake, packs them into 128-bit
// lines and commits each line to RAM over the request/acknowledge port.
// Once the last (possibly partial) line is committed, o_boot_ready releases
// the CPU. Words beyond MAX_BYTES are dropped and flagged on o_overflow.
module boot_image_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MAX_BYTES = 32'h0100_0000
) (
    input  logic                       clk27mhz,
    input  logic                       resetn,
    input  logic [31:0]                i_data,
    input  logic                       i_we,
    input  logic                       i_done,
    output logic [7:0]                 o_ctrl_state,
    boot_image_writer_if.master        mem,
    output logic                       o_boot_ready,
    output logic                       o_overflow,
    output logic [31:0]                o_word_count,
    output logic [31:0]                o_checksum
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK   = 3'd1,
        ST_WRITE = 3'd2,
        ST_FLUSH = 3'd3,
        ST_READY = 3'd4
    } state_t;

    // Byte-enable vector for a line: each lane-valid bit covers four bytes.
    function automatic logic [15:0] lane_mask(input logic [3:0] valid);
        logic [15:0] m;
        m = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            m[4*k +: 4] = {4{valid[k]}};
        end
        return m;
    endfunction

    state_t         state_q,      state_d;
    logic [127:0]   line_q,       line_d;
    logic [1:0]     lane_q,       lane_d;
    logic [3:0]     valid_q,      valid_d;
    logic [27:0]    line_idx_q,   line_idx_d;
    logic           captured_q,   captured_d;
    logic           mem_req_q,    mem_req_d;
    logic [31:0]    mem_addr_q,   mem_addr_d;
    logic [15:0]    mem_mask_q,   mem_mask_d;
    logic           boot_ready_q, boot_ready_d;
    logic           overflow_q,   overflow_d;
    logic [31:0]    word_count_q, word_count_d;
    logic [31:0]    checksum_q,   checksum_d;

    // Room check done in 34 bits so a large word count cannot wrap the
    // byte count back under the limit.
    logic           room_s;
    assign room_s = ({word_count_q, 2'b00} < {2'b00, MAX_BYTES});

    // Next-state and datapath computation for the handshake/line-write FSM.
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        lane_d       = lane_q;
        valid_d      = valid_q;
        line_idx_d   = line_idx_q;
        captured_d   = captured_q;
        mem_req_d    = mem_req_q;
        mem_mask_d   = mem_mask_q;
        boot_ready_d = boot_ready_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;

        case (state_q)
            ST_IDLE: begin
                if (i_we) begin
                    // A pending word always wins over i_done in the same cycle.
                    if (room_s) begin
                        line_d[{lane_q, 5'b00000} +: 32] = i_data;
                        valid_d[lane_q]                  = 1'b1;
                        word_count_d                     = word_count_q + 32'd1;
                        checksum_d                       = checksum_q + i_data;
                        captured_d                       = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                        captured_d = 1'b0;
                    end
                    state_d = ST_ACK;
                end else if (i_done) begin
                    if (|valid_q) begin
                        state_d    = ST_FLUSH;
                        mem_req_d  = 1'b1;
                        mem_mask_d = lane_mask(valid_q);
                    end else begin
                        state_d      = ST_READY;
                        boot_ready_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACK: begin
                // Hold busy until the loader drops WE so one word is taken once.
                if (!i_we) begin
                    if (captured_q && (lane_q == 2'd3)) begin
                        state_d    = ST_WRITE;
                        mem_req_d  = 1'b1;
                        mem_mask_d = lane_mask(valid_q);
                    end else begin
                        if (captured_q) begin
                            lane_d = lane_q + 2'd1;
                        end else begin
                            lane_d = lane_q;
                        end
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_ACK;
                end
            end

            ST_WRITE, ST_FLUSH: begin
                if (mem.mem_ack) begin
                    valid_d    = 4'b0000;
                    lane_d     = 2'd0;
                    line_idx_d = line_idx_q + 28'd1;
                    mem_req_d  = 1'b0;
                    mem_mask_d = 16'h0000;
                    if (state_q == ST_FLUSH) begin
                        state_d      = ST_READY;
                        boot_ready_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_READY: begin
                // Terminal: the CPU is running; only reset leaves this state.
                state_d      = ST_READY;
                boot_ready_d = 1'b1;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // The address register always tracks the current line index, so it is
        // already valid when a request is raised and stays put until the ack.
        mem_addr_d = BASE_ADDR + {line_idx_d, 4'b0000};
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk27mhz) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            line_q       <= 128'd0;
            lane_q       <= 2'd0;
            valid_q      <= 4'b0000;
            line_idx_q   <= 28'd0;
            captured_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_mask_q   <= 16'h0000;
            boot_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= 32'd0;
            checksum_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            lane_q       <= lane_d;
            valid_q      <= valid_d;
            line_idx_q   <= line_idx_d;
            captured_q   <= captured_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_mask_q   <= mem_mask_d;
            boot_ready_q <= boot_ready_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
        end
    end

    assign o_ctrl_state  = {5'b00000, state_q};
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = line_q;
    assign mem.mem_mask  = mem_mask_q;
    assign o_boot_ready  = boot_ready_q;
    assign o_overflow    = overflow_q;
    assign o_word_count  = word_count_q;
    assign o_checksum    = checksum_q;

endmodule

// File: tb/tb_boot_image_writer.sv
// Directed bench for boot_image_writer. Two instances share the loader and
// ack stimulus: dut_a uses default parameters, dut_b a 16-byte image limit at
// a nonzero base. The instance not under test is held in reset. Expected line
// writes are pushed to a queue when the bench model sees a line complete and
// popped when the DUT raises its request.
module tb_boot_image_writer;

    localparam logic [31:0] BASE_B = 32'h0000_1000;
    localparam logic [31:0] MAX_B  = 32'd16;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  mask;
        logic [7:0]   next;
    } req_t;

    logic clk27mhz = 1'b0;
    always #5 clk27mhz = ~clk27mhz;

    logic         resetn_a, resetn_b, sel;
    logic [31:0]  i_data;
    logic         i_we, i_done, mem_ack;
    logic [7:0]   ctrl_a, ctrl_b;
    logic         ready_a, ready_b, ovf_a, ovf_b;
    logic [31:0]  count_a, count_b, sum_a, sum_b;

    boot_image_writer_if bif_a();
    boot_image_writer_if bif_b();
    assign bif_a.mem_ack = mem_ack;
    assign bif_b.mem_ack = mem_ack;

    boot_image_writer dut_a (
        .clk27mhz(clk27mhz), .resetn(resetn_a), .i_data(i_data), .i_we(i_we),
        .i_done(i_done), .o_ctrl_state(ctrl_a), .mem(bif_a),
        .o_boot_ready(ready_a), .o_overflow(ovf_a),
        .o_word_count(count_a), .o_checksum(sum_a)
    );

    boot_image_writer #(.BASE_ADDR(BASE_B), .MAX_BYTES(MAX_B)) dut_b (
        .clk27mhz(clk27mhz), .resetn(resetn_b), .i_data(i_data), .i_we(i_we),
        .i_done(i_done), .o_ctrl_state(ctrl_b), .mem(bif_b),
        .o_boot_ready(ready_b), .o_overflow(ovf_b),
        .o_word_count(count_b), .o_checksum(sum_b)
    );

    // Observation of whichever instance is under test.
    logic [7:0]   ctrl_m;
    logic         req_m, ready_m, ovf_m;
    logic [31:0]  addr_m, count_m, sum_m;
    logic [127:0] wdata_m;
    logic [15:0]  mask_m;
    assign ctrl_m  = sel ? ctrl_b : ctrl_a;
    assign req_m   = sel ? bif_b.mem_req : bif_a.mem_req;
    assign addr_m  = sel ? bif_b.mem_addr : bif_a.mem_addr;
    assign wdata_m = sel ? bif_b.mem_wdata : bif_a.mem_wdata;
    assign mask_m  = sel ? bif_b.mem_mask : bif_a.mem_mask;
    assign ready_m = sel ? ready_b : ready_a;
    assign ovf_m   = sel ? ovf_b : ovf_a;
    assign count_m = sel ? count_b : count_a;
    assign sum_m   = sel ? sum_b : sum_a;

    int total = 0;
    int bad   = 0;

    // Bench model of the writer.
    logic [31:0]  m_base, m_max, m_count, m_sum;
    logic [127:0] m_line;
    logic [3:0]   m_valid;
    logic [1:0]   m_lane;
    logic [27:0]  m_line_idx;
    logic         m_ovf;
    req_t         exp_q[$];

    function automatic logic [15:0] exp_mask(input logic [3:0] v);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[k] = v[k/4];
        return r;
    endfunction

    function automatic logic [127:0] bit_mask(input logic [15:0] m);
        logic [127:0] r;
        for (int k = 0; k < 128; k++) r[k] = m[k/8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk27mhz);
        #1;
    endtask

    task automatic m_reset(input logic [31:0] base, input logic [31:0] max);
        m_base = base; m_max = max; m_count = 32'd0; m_sum = 32'd0;
        m_line = 128'd0; m_valid = 4'b0000; m_lane = 2'd0;
        m_line_idx = 28'd0; m_ovf = 1'b0;
        exp_q.delete();
    endtask

    // One-cycle reset pulse on the instance under test, then check reset state.
    task automatic reset_sel(input logic [31:0] base, input logic [31:0] max);
        if (sel) resetn_b = 1'b0; else resetn_a = 1'b0;
        step();
        m_reset(base, max);
        chk("rst_ctrl", ctrl_m, 8'd0);
        chk("rst_req", req_m, 1'b0);
        chk("rst_addr", addr_m, m_base);
        chk("rst_wdata", wdata_m, 128'd0);
        chk("rst_mask", mask_m, 16'h0000);
        chk("rst_ready", ready_m, 1'b0);
        chk("rst_ovf", ovf_m, 1'b0);
        chk("rst_count", count_m, 32'd0);
        chk("rst_sum", sum_m, 32'd0);
        if (sel) resetn_b = 1'b1; else resetn_a = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] d, input int hold);
        logic room;
        room = ({m_count, 2'b00} < {2'b00, m_max});
        i_data = d; i_we = 1'b1;
        step();
        chk("cap_state", ctrl_m, 8'd1);
        repeat (hold) step();
        if (hold > 0) chk("we_hold_state", ctrl_m, 8'd1);
        if (room) begin
            m_line[{m_lane, 5'b00000} +: 32] = d;
            m_valid[m_lane] = 1'b1;
            m_count = m_count + 32'd1;
            m_sum   = m_sum + d;
        end else begin
            m_ovf = 1'b1;
        end
        i_we = 1'b0;
        step();
        if (room && m_lane == 2'd3) begin
            exp_q.push_back('{m_base + {m_line_idx, 4'b0000}, m_line, exp_mask(m_valid), 8'd0});
            chk("line_state", ctrl_m, 8'd2);
        end else begin
            if (room) m_lane = m_lane + 2'd1;
            chk("release_state", ctrl_m, 8'd0);
        end
        chk("word_count", count_m, m_count);
        chk("checksum", sum_m, m_sum);
        chk("overflow", ovf_m, m_ovf);
    endtask

    // Wait for a request, compare against the scoreboard, hold the ack off for
    // `delay` cycles (optionally offering a word meanwhile), then acknowledge.
    task automatic serve_req(input int delay, input logic we_probe);
        req_t e;
        int   n;
        n = 0;
        while (req_m !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", req_m, 1'b1);
        if (exp_q.size() == 0) begin
            chk("unexpected_req", req_m, 1'b0);
            return;
        end
        e = exp_q.pop_front();
        chk("mem_addr", addr_m, e.addr);
        chk("mem_mask", mask_m, e.mask);
        chk("mem_wdata", wdata_m & bit_mask(e.mask), e.wdata & bit_mask(e.mask));
        if (we_probe) begin
            i_data = 32'hDEAD_BEEF;
            i_we   = 1'b1;
        end
        for (int i = 0; i < delay; i++) begin
            step();
            chk("wait_req", req_m, 1'b1);
            chk("wait_addr", addr_m, e.addr);
            chk("wait_mask", mask_m, e.mask);
            chk("wait_wdata", wdata_m & bit_mask(e.mask), e.wdata & bit_mask(e.mask));
            chk("wait_state", ctrl_m, (e.next == 8'd4) ? 8'd3 : 8'd2);
        end
        i_we = 1'b0;
        chk("wait_count", count_m, m_count);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        m_valid = 4'b0000; m_lane = 2'd0; m_line_idx = m_line_idx + 28'd1;
        chk("req_drop", req_m, 1'b0);
        chk("post_ack_state", ctrl_m, e.next);
        chk("post_ack_addr", addr_m, m_base + {m_line_idx, 4'b0000});
    endtask

    task automatic send_done();
        i_done = 1'b1;
        step();
        if (m_valid != 4'b0000) begin
            exp_q.push_back('{m_base + {m_line_idx, 4'b0000}, m_line, exp_mask(m_valid), 8'd4});
            chk("flush_state", ctrl_m, 8'd3);
            serve_req(0, 1'b0);
        end else begin
            chk("ready_state", ctrl_m, 8'd4);
            chk("no_flush_req", req_m, 1'b0);
        end
        chk("boot_ready", ready_m, 1'b1);
        i_done = 1'b0;
    endtask

    initial begin
        resetn_a = 1'b0; resetn_b = 1'b0; sel = 1'b0;
        i_data = 32'd0; i_we = 1'b0; i_done = 1'b0; mem_ack = 1'b0;
        step();
        step();

        // Instance A: default parameters.
        reset_sel(32'h0000_0000, 32'h0100_0000);

        // Stray ack in IDLE changes nothing.
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("stray_ack_state", ctrl_m, 8'd0);
        chk("stray_ack_addr", addr_m, m_base);

        // Full line, immediate ack.
        send_word(32'h1111_1111, 0);
        send_word(32'h2222_2222, 0);
        send_word(32'h3333_3333, 0);
        send_word(32'h4444_4444, 0);
        serve_req(0, 1'b0);
        chk("sum_line1", sum_m, 32'hAAAA_AAAA);
        chk("count_line1", count_m, 32'd4);

        // WE held for 5 extra cycles: a single capture.
        send_word(32'h5555_5555, 5);
        chk("count_held", count_m, 32'd5);
        send_word(32'h6666_6666, 0);

        // Partial line flush and terminal READY.
        send_done();
        chk("ready_ctrl", ctrl_m, 8'd4);
        i_we = 1'b1; i_data = 32'h7777_7777;
        repeat (3) step();
        chk("ready_ignore_we", ctrl_m, 8'd4);
        chk("ready_count", count_m, m_count);
        i_we = 1'b0;

        // Delayed ack with a word offered during the wait.
        reset_sel(32'h0000_0000, 32'h0100_0000);
        for (int i = 0; i < 4; i++) send_word($urandom, 0);
        serve_req(10, 1'b1);

        // Reset while a line write is pending abandons the request.
        for (int i = 0; i < 4; i++) send_word($urandom, 0);
        chk("pre_reset_req", req_m, 1'b1);
        reset_sel(32'h0000_0000, 32'h0100_0000);

        // WE and DONE together: word first, then flush of a single lane.
        i_done = 1'b1;
        send_word(32'h0BAD_F00D, 0);
        send_done();

        // Instance B: 16-byte limit, nonzero base.
        resetn_a = 1'b0;
        sel = 1'b1;
        reset_sel(BASE_B, MAX_B);
        send_word(32'h0000_0001, 0);
        send_word(32'h0000_0002, 0);
        send_word(32'h0000_0003, 0);
        send_word(32'hFFFF_FFFF, 0);
        serve_req(0, 1'b0);
        send_word(32'h1234_5678, 0);
        chk("ovf_flag", ovf_m, 1'b1);
        chk("ovf_count", count_m, 32'd4);
        send_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
